// File: rtl/pewpew_pkg.sv
// Shared types and constants for the pulser run controller.
// Timing widths and reset defaults match the pulser core.
package pewpew_pkg;

    localparam int N_BITS      = 20;
    localparam int N_SHOT_BITS = 16;

    localparam logic [N_BITS-1:0] DEF_REPEAT_PERIOD = 20'd800000;
    localparam logic [N_BITS-1:0] DEF_DELAY         = 20'd1200;
    localparam logic [N_BITS-1:0] DEF_EXPOSURE      = 20'd360;

    localparam int CFG_W = 3 * N_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } seq_state_e;

endpackage

// File: rtl/pulse_sequencer_if.sv
// Command-side and pulser-side bundle of the run controller.
// master drives commands and camera; slave is the sequencer.
interface pulse_sequencer_if;
    import pewpew_pkg::*;

    logic                   start;
    logic                   abort;
    logic [N_SHOT_BITS-1:0] shot_count;
    logic                   cfg_valid;
    logic [N_BITS-1:0]      cfg_repeat_period;
    logic [N_BITS-1:0]      cfg_delay;
    logic [N_BITS-1:0]      cfg_exposure;
    logic                   camera;

    logic                   pulser_reset;
    logic [N_BITS-1:0]      repeat_period;
    logic [N_BITS-1:0]      delay;
    logic [N_BITS-1:0]      exposure_time;
    logic [N_SHOT_BITS-1:0] shots_done;
    logic                   busy;
    logic                   done;
    logic                   aborted;

    modport master (
        output start, abort, shot_count,
        output cfg_valid, cfg_repeat_period,
        output cfg_delay, cfg_exposure, camera,
        input  pulser_reset, repeat_period,
        input  delay, exposure_time,
        input  shots_done, busy, done, aborted
    );

    modport slave (
        input  start, abort, shot_count,
        input  cfg_valid, cfg_repeat_period,
        input  cfg_delay, cfg_exposure, camera,
        output pulser_reset, repeat_period,
        output delay, exposure_time,
        output shots_done, busy, done, aborted
    );

endinterface

// File: rtl/pulse_sequencer_cfg_shadow.sv
// Staged/applied register pair for the timing values.
// A write coinciding with a boundary skips the staging stage.
module cfg_shadow #(
    parameter int         W   = 8,
    parameter logic [W-1:0] DEF = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_i,
    input  logic [W-1:0] din_i,
    input  logic         copy_i,
    input  logic         bound_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage_q;
    logic [W-1:0] apply_q;
    logic [W-1:0] apply_d;

    always_comb begin
        apply_d = apply_q;
        if (bound_i) begin
            apply_d = wr_i ? din_i : stage_q;
        end else if (copy_i) begin
            apply_d = stage_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= DEF;
            apply_q <= DEF;
        end else begin
            if (wr_i) stage_q <= din_i;
            apply_q <= apply_d;
        end
    end

    assign q_o = apply_q;

endmodule

// File: rtl/pulse_sequencer.sv
// Burst run controller: counts camera falls, gates pulser reset,
// and applies staged timing only while stopped or at a boundary.
module pulse_sequencer
    import pewpew_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    pulse_sequencer_if.slave  bus
);

    localparam logic [N_SHOT_BITS-1:0] SHOT_ONE =
        {{(N_SHOT_BITS-1){1'b0}}, 1'b1};

    seq_state_e             state_q;
    logic                   camera_q;
    logic [N_SHOT_BITS-1:0] target_q;
    logic [N_SHOT_BITS-1:0] shots_q;
    logic                   prst_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   aborted_q;

    logic                   bound;
    logic [N_SHOT_BITS-1:0] shots_p1;
    logic [N_SHOT_BITS-1:0] shots_d;
    logic                   last_shot;
    logic                   in_run;

    assign bound    = camera_q & ~bus.camera;
    assign shots_p1 = shots_q + SHOT_ONE;
    assign in_run   = (state_q == RUN);

    // Continuous bursts hold at all-ones instead of wrapping.
    assign shots_d = ((target_q == '0) && (&shots_q))
                   ? shots_q : shots_p1;
    assign last_shot = (target_q != '0) && (shots_p1 == target_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            camera_q  <= 1'b0;
            target_q  <= '0;
            shots_q   <= '0;
            prst_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            camera_q <= bus.camera;
            case (state_q)
                IDLE: begin
                    prst_q <= 1'b1;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (bus.start && !bus.abort) begin
                        state_q   <= RUN;
                        target_q  <= bus.shot_count;
                        shots_q   <= '0;
                        aborted_q <= 1'b0;
                        prst_q    <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                RUN: begin
                    if (bound) shots_q <= shots_d;
                    if ((bound && last_shot) || bus.abort) begin
                        state_q <= STOP;
                        prst_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        // Count completion outranks a same-cycle abort.
                        if (!(bound && last_shot)) aborted_q <= 1'b1;
                    end
                end
                STOP: begin
                    state_q <= IDLE;
                    prst_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    prst_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    logic [CFG_W-1:0] cfg_in;
    logic [CFG_W-1:0] cfg_out;

    assign cfg_in = {bus.cfg_repeat_period,
                     bus.cfg_delay,
                     bus.cfg_exposure};

    cfg_shadow #(
        .W   (CFG_W),
        .DEF ({DEF_REPEAT_PERIOD, DEF_DELAY, DEF_EXPOSURE})
    ) u_shadow (
        .clk     (clk),
        .reset   (reset),
        .wr_i    (bus.cfg_valid),
        .din_i   (cfg_in),
        .copy_i  (!in_run),
        .bound_i (in_run && bound),
        .q_o     (cfg_out)
    );

    assign bus.repeat_period = cfg_out[3*N_BITS-1:2*N_BITS];
    assign bus.delay         = cfg_out[2*N_BITS-1:N_BITS];
    assign bus.exposure_time = cfg_out[N_BITS-1:0];

    assign bus.pulser_reset = prst_q;
    assign bus.shots_done   = shots_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.aborted      = aborted_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Scenario bench for pulse_sequencer with shot/burst scoreboards.
module tb_pulse_sequencer;
    import pewpew_pkg::*;

    typedef struct {
        int shots;
        bit ab;
    } end_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   model_shots = 0;
    int   exp_q[$];
    end_t end_q[$];

    pulse_sequencer_if bus();

    pulse_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_burst(input int n);
        bus.shot_count = n[N_SHOT_BITS-1:0];
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        bus.shot_count = '0;
        model_shots = 0;
        total++;
        if (bus.pulser_reset !== 1'b0) begin
            bad++;
            $display("FAIL start_prst got=%0b want=0", bus.pulser_reset);
        end
    endtask

    task automatic shots(input int n);
        for (int i = 0; i < n; i++) begin
            int e;
            model_shots++;
            exp_q.push_back(model_shots);
            bus.camera = 1'b1;
            cyc();
            cyc();
            bus.camera = 1'b0;
            cyc();
            e = exp_q.pop_front();
            total++;
            if (int'(bus.shots_done) !== e) begin
                bad++;
                $display("FAIL shot_count got=%0d want=%0d",
                         bus.shots_done, e);
            end
        end
    endtask

    task automatic end_burst(input int maxc);
        end_t e;
        int   seen;
        seen = 0;
        for (int i = 0; i < maxc; i++) begin
            if (bus.done === 1'b1) begin
                seen = 1;
                break;
            end
            cyc();
        end
        e = end_q.pop_front();
        total++;
        if (seen == 0) begin
            bad++;
            $display("FAIL done_timeout got=0 want=1");
        end else begin
            if (int'(bus.shots_done) !== e.shots ||
                bus.aborted !== e.ab ||
                bus.pulser_reset !== 1'b1 ||
                bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL stop_cycle got=%0d/%0b/%0b/%0b want=%0d/%0b/1/0",
                         bus.shots_done, bus.aborted,
                         bus.pulser_reset, bus.busy, e.shots, e.ab);
            end
            cyc();
            total++;
            if (bus.done !== 1'b0 || bus.pulser_reset !== 1'b1) begin
                bad++;
                $display("FAIL idle_after got=%0b/%0b want=0/1",
                         bus.done, bus.pulser_reset);
            end
        end
    endtask

    task automatic set_cfg(input logic [N_BITS-1:0] rp);
        bus.cfg_valid = 1'b1;
        bus.cfg_repeat_period = rp;
        bus.cfg_delay = DEF_DELAY;
        bus.cfg_exposure = DEF_EXPOSURE;
        cyc();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        total++;
        if (bus.pulser_reset !== 1'b1 || bus.shots_done !== '0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.aborted !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags got=%0b/%0d/%0b/%0b/%0b want=1/0/0/0/0",
                     bus.pulser_reset, bus.shots_done, bus.busy,
                     bus.done, bus.aborted);
        end
        total++;
        if (bus.repeat_period !== DEF_REPEAT_PERIOD ||
            bus.delay !== DEF_DELAY ||
            bus.exposure_time !== DEF_EXPOSURE) begin
            bad++;
            $display("FAIL reset_cfg got=%0d/%0d/%0d want=800000/1200/360",
                     bus.repeat_period, bus.delay, bus.exposure_time);
        end
    endtask

    task automatic test_basic_burst();
        begin_burst(3);
        end_q.push_back('{shots: 3, ab: 1'b0});
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_busy got=%0b want=1", bus.busy);
        end
        shots(3);
        end_burst(4);
    endtask

    task automatic test_continuous();
        begin_burst(0);
        end_q.push_back('{shots: 5, ab: 1'b1});
        shots(5);
        cyc();
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        end_burst(4);
    endtask

    task automatic test_abort_mid();
        begin_burst(4);
        end_q.push_back('{shots: 1, ab: 1'b1});
        shots(1);
        bus.camera = 1'b1;
        cyc();
        cyc();
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        bus.camera = 1'b0;
        end_burst(4);
        cyc();
        total++;
        if (bus.shots_done !== 16'd1) begin
            bad++;
            $display("FAIL abort_partial got=%0d want=1", bus.shots_done);
        end
    endtask

    task automatic test_cfg_shadow();
        begin_burst(0);
        end_q.push_back('{shots: 2, ab: 1'b1});
        cyc();
        set_cfg(20'd400000);
        repeat (3) cyc();
        total++;
        if (bus.repeat_period !== DEF_REPEAT_PERIOD) begin
            bad++;
            $display("FAIL cfg_hold got=%0d want=800000", bus.repeat_period);
        end
        shots(1);
        total++;
        if (bus.repeat_period !== 20'd400000) begin
            bad++;
            $display("FAIL cfg_bound got=%0d want=400000", bus.repeat_period);
        end
        model_shots++;
        exp_q.push_back(model_shots);
        bus.camera = 1'b1;
        cyc();
        cyc();
        bus.camera = 1'b0;
        set_cfg(20'd300000);
        total++;
        if (bus.repeat_period !== 20'd300000 ||
            int'(bus.shots_done) !== exp_q.pop_front()) begin
            bad++;
            $display("FAIL cfg_bypass got=%0d/%0d want=300000/2",
                     bus.repeat_period, bus.shots_done);
        end
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        end_burst(4);
        set_cfg(20'd500000);
        total++;
        if (bus.repeat_period !== 20'd300000) begin
            bad++;
            $display("FAIL cfg_idle_t1 got=%0d want=300000", bus.repeat_period);
        end
        cyc();
        total++;
        if (bus.repeat_period !== 20'd500000) begin
            bad++;
            $display("FAIL cfg_idle_t2 got=%0d want=500000", bus.repeat_period);
        end
        set_cfg(DEF_REPEAT_PERIOD);
        cyc();
    endtask

    task automatic test_collisions();
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.shot_count = 16'd2;
        cyc();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bus.busy !== 1'b0 || bus.pulser_reset !== 1'b1 ||
                bus.done !== 1'b0) begin
                bad++;
                $display("FAIL start_abort got=%0b/%0b/%0b want=0/1/0",
                         bus.busy, bus.pulser_reset, bus.done);
            end
            cyc();
        end
        begin_burst(2);
        end_q.push_back('{shots: 2, ab: 1'b0});
        shots(1);
        bus.camera = 1'b1;
        cyc();
        cyc();
        bus.camera = 1'b0;
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        end_burst(4);
        begin_burst(5);
        end_q.push_back('{shots: 3, ab: 1'b1});
        shots(2);
        bus.start = 1'b1;
        bus.shot_count = 16'd1;
        cyc();
        bus.start = 1'b0;
        total++;
        if (bus.shots_done !== 16'd2 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL start_in_run got=%0d/%0b want=2/1",
                     bus.shots_done, bus.busy);
        end
        shots(1);
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL target_kept got=%0b want=1", bus.busy);
        end
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        end_burst(4);
    endtask

    task automatic test_reset_mid_run();
        set_cfg(20'd400000);
        cyc();
        begin_burst(0);
        shots(2);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        total++;
        if (bus.pulser_reset !== 1'b1 || bus.shots_done !== '0 ||
            bus.repeat_period !== DEF_REPEAT_PERIOD ||
            bus.done !== 1'b0 || bus.aborted !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid got=%0b/%0d/%0d/%0b/%0b want=1/0/800000/0/0",
                     bus.pulser_reset, bus.shots_done,
                     bus.repeat_period, bus.done, bus.aborted);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_no_done got=%0b/%0b want=0/0",
                         bus.done, bus.busy);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.shot_count = '0;
        bus.cfg_valid = 1'b0;
        bus.cfg_repeat_period = '0;
        bus.cfg_delay = '0;
        bus.cfg_exposure = '0;
        bus.camera = 1'b0;
        test_reset();
        test_basic_burst();
        test_continuous();
        test_abort_mid();
        test_cfg_shadow();
        test_collisions();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
